// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Package name is disp_pkg; the leading-zero helper is only used when LEADING_ZERO_BLANK_EN is defined.
package disp_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] ANODE_OFF  = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_e;

  // A slot is dark when it and every more-significant digit are zero; digit 0 always shows.
  function automatic logic leadZero(input logic [15:0] digits, input logic [1:0] idx);
    logic allZero;
    allZero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && digits[4*i +: 4] != 4'd0) allZero = 1'b0;
    end
    return (idx != 2'd0) && allZero;
  endfunction

  function automatic logic [3:0] anodeFor(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_prescaler.sv
// Per-slot cycle counter for the scan controller. Flags describe the count the
// prescaler will hold next cycle, so the top level can register its outputs in step.
module scan_prescaler #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic slot_tick,
  output logic slot_last,
  output logic in_blank
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign slot_tick = run && (int'(count_q) == CLK_DIV - 1);

  always_comb begin
    count_d = '0;
    if (run && !slot_tick) count_d = count_q + CW'(1);
  end

  assign in_blank  = int'(count_d) < BLANK_CYCLES;
  assign slot_last = int'(count_d) == CLK_DIV - 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Double-buffered 4-digit seven-segment scan controller with per-slot blanking gap.
// Define LEADING_ZERO_BLANK_EN to keep leading-zero digit slots dark.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_digits,
  output logic [1:0]  refreshcounter,
  output logic [3:0]  one_digit,
  output logic [3:0]  anode,
  output logic        blank,
  output logic        frame_done
);

  scan_state_e state_q;
  logic [1:0]  refresh_q;
  logic [3:0]  oneDigit_q;
  logic [3:0]  anode_q;
  logic        blank_q;
  logic        frameDone_q;
  logic        supp_q;
  logic [15:0] active_q;
  logic [15:0] pending_q;
  logic        pendingFull_q;

  logic        slotTick;
  logic        slotLast;
  logic        inBlank;
  logic        copy;
  logic        accept;
  logic        newSlot;
  logic        lzFlag;
  logic        suppNext;
  logic        litNext;
  logic [1:0]  slotIdx;
  logic [1:0]  refreshNext;
  logic [15:0] activeNext;
  logic [3:0]  slotDigit;

  scan_prescaler #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .run       (enable && (state_q != IDLE)),
    .slot_tick (slotTick),
    .slot_last (slotLast),
    .in_blank  (inBlank)
  );

  assign copy       = frameDone_q && pendingFull_q;
  assign accept     = load_valid && !pendingFull_q;
  assign activeNext = copy ? pending_q : active_q;

  // A new slot starts either when scanning leaves IDLE or when the prescaler wraps.
  assign slotIdx     = (state_q == IDLE) ? 2'd0 : refresh_q + 2'd1;
  assign newSlot     = (state_q == IDLE) ? enable : (enable && slotTick);
  assign refreshNext = newSlot ? slotIdx : refresh_q;
  assign slotDigit   = activeNext[{slotIdx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  assign lzFlag = leadZero(activeNext, slotIdx);
`else
  assign lzFlag = 1'b0;
`endif

  assign suppNext = newSlot ? lzFlag : supp_q;
  assign litNext  = !inBlank && !suppNext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      refresh_q     <= 2'd0;
      oneDigit_q    <= 4'd0;
      anode_q       <= ANODE_OFF;
      blank_q       <= 1'b1;
      frameDone_q   <= 1'b0;
      supp_q        <= 1'b0;
      active_q      <= 16'd0;
      pending_q     <= 16'd0;
      pendingFull_q <= 1'b0;
    end else begin
      // copy and accept are mutually exclusive: one needs pending full, the other empty
      if (copy) begin
        active_q      <= pending_q;
        pendingFull_q <= 1'b0;
      end
      if (accept) begin
        pending_q     <= load_digits;
        pendingFull_q <= 1'b1;
      end

      if (!enable) begin
        state_q     <= IDLE;
        refresh_q   <= 2'd0;
        anode_q     <= ANODE_OFF;
        blank_q     <= 1'b1;
        frameDone_q <= 1'b0;
      end else begin
        state_q     <= inBlank ? BLANK : SHOW;
        refresh_q   <= refreshNext;
        supp_q      <= suppNext;
        anode_q     <= litNext ? anodeFor(refreshNext) : ANODE_OFF;
        blank_q     <= !litNext;
        frameDone_q <= slotLast && (refreshNext == 2'd3);
        if (newSlot) oneDigit_q <= slotDigit;
      end
    end
  end

  assign load_ready     = !pendingFull_q;
  assign refreshcounter = refresh_q;
  assign one_digit      = oneDigit_q;
  assign anode          = anode_q;
  assign blank          = blank_q;
  assign frame_done     = frameDone_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl against a cycle-count based reference model.
// The model honours LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_display_scan_ctrl;

  localparam int CLK_DIV      = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME        = 4 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_digits = 16'd0;
  logic        load_ready;
  logic [1:0]  refreshcounter;
  logic [3:0]  one_digit;
  logic [3:0]  anode;
  logic        blank;
  logic        frame_done;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: scan position is just cycles elapsed since scanning began.
  bit          mRun;
  int          mT;
  logic [15:0] mActive;
  logic [15:0] mPending;
  bit          mFull;
  logic [3:0]  mDigit;
  bit          mSupp;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_digits    (load_digits),
    .refreshcounter (refreshcounter),
    .one_digit      (one_digit),
    .anode          (anode),
    .blank          (blank),
    .frame_done     (frame_done)
  );

  function automatic bit slotSuppressed(input logic [15:0] digits, input int slot);
`ifdef LEADING_ZERO_BLANK_EN
    return (slot != 0) && ((digits >> (4 * slot)) == 16'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit modelFdNow();
    return mRun && (mT % CLK_DIV == CLK_DIV - 1) && ((mT / CLK_DIV) % 4 == 3);
  endfunction

  function automatic logic [15:0] randBcd();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic modelReset();
    mRun = 0; mT = 0; mActive = 16'd0; mPending = 16'd0;
    mFull = 0; mDigit = 4'd0; mSupp = 0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int phase;
    int slot;
    bit lit;
    logic [3:0] expAnode;
    phase    = mT % CLK_DIV;
    slot     = (mT / CLK_DIV) % 4;
    lit      = mRun && (phase >= BLANK_CYCLES) && !mSupp;
    expAnode = lit ? ~(4'b0001 << slot) : 4'hF;
    check("anode", anode, expAnode);
    check("blank", blank, !lit);
    check("refreshcounter", refreshcounter, mRun ? 2'(slot) : 2'd0);
    check("frame_done", frame_done, mRun && phase == CLK_DIV - 1 && slot == 3);
    check("load_ready", load_ready, !mFull);
    check("one_digit", one_digit, mDigit);
  endtask

  task automatic applyStimulus(input bit en, input bit vld, input logic [15:0] data, output bit acc);
    bit fdNow;
    int slot;
    enable = en; load_valid = vld; load_digits = data;
    fdNow = modelFdNow();
    acc   = vld && !mFull;
    @(posedge clk);
    if (fdNow && mFull) begin
      mActive = mPending;
      mFull   = 0;
    end
    if (acc) begin
      mPending = data;
      mFull    = 1;
    end
    if (!mRun) begin
      if (en) begin
        mRun = 1;
        mT   = 0;
      end
    end else if (!en) begin
      mRun = 0;
    end else begin
      mT = (mT + 1) % FRAME;
    end
    if (mRun && (mT % CLK_DIV == 0)) begin
      slot   = (mT / CLK_DIV) % 4;
      mDigit = 4'(mActive >> (4 * slot));
      mSupp  = slotSuppressed(mActive, slot);
    end
    #1;
    checkOutput();
  endtask

  task automatic offerUntilAccepted(input logic [15:0] data);
    bit acc;
    bit done;
    done = 0;
    for (int i = 0; i < 3 * FRAME && !done; i++) begin
      applyStimulus(1, 1, data, acc);
      done = acc;
    end
    assertCount++;
    assert (done) else begin
      failCount++;
      $error("[TB] FAIL offer timeout: accepted %0d expected 1", done);
    end
  endtask

  initial begin
    bit acc;
    logic [15:0] offers[$];
    modelReset();

    $display("[TB] reset with enable high");
    reset = 1; enable = 1;
    @(posedge clk); #1; checkOutput();
    @(posedge clk); #1; checkOutput();
    reset = 0;

    $display("[TB] basic scan");
    applyStimulus(0, 1, 16'h1234, acc);
    repeat (2) applyStimulus(0, 0, 16'h0, acc);
    repeat (3 * FRAME) applyStimulus(1, 0, 16'h0, acc);

    $display("[TB] backpressure");
    offers.push_back(16'h5678);
    offers.push_back(16'h9999);
    for (int i = 0; i < 4 * FRAME && offers.size() > 0; i++) begin
      applyStimulus(1, 1, offers[0], acc);
      if (acc) void'(offers.pop_front());
    end
    assertCount++;
    assert (offers.size() == 0) else begin
      failCount++;
      $error("[TB] FAIL backpressure timeout: %0d offers left expected 0", offers.size());
    end
    repeat (3 * FRAME) applyStimulus(1, 0, 16'h0, acc);

    $display("[TB] boundary collision");
    for (int i = 0; i < 2 * FRAME && (mFull || !modelFdNow()); i++) applyStimulus(1, 0, 16'h0, acc);
    check("collision frame_done", frame_done, 1'b1);
    applyStimulus(1, 1, 16'h4321, acc);
    repeat (2 * FRAME + 4) applyStimulus(1, 0, 16'h0, acc);

    $display("[TB] enable drop in slot 2");
    for (int i = 0; i < 2 * FRAME && !(mRun && mT == 2 * CLK_DIV + 4); i++) applyStimulus(1, 0, 16'h0, acc);
    check("drop position", refreshcounter, 2'd2);
    repeat (3) applyStimulus(0, 0, 16'h0, acc);
    repeat (2 * FRAME) applyStimulus(1, 0, 16'h0, acc);

    $display("[TB] leading zero patterns");
    offerUntilAccepted(16'h0070);
    repeat (2 * FRAME + 2) applyStimulus(1, 0, 16'h0, acc);
    offerUntilAccepted(16'h0000);
    repeat (2 * FRAME + 2) applyStimulus(1, 0, 16'h0, acc);

    $display("[TB] reset mid-operation");
    offerUntilAccepted(16'h8642);
    repeat (5) applyStimulus(1, 0, 16'h0, acc);
    #3 reset = 1;
    #1 modelReset();
    checkOutput();
    @(posedge clk); #1; checkOutput();
    reset = 0;
    repeat (FRAME + 4) applyStimulus(1, 0, 16'h0, acc);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) >= 3, $urandom_range(0, 3) == 0, randBcd(), acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
